// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - MULT/MULTU/MTHI/MTLO sequencer driving a pipelined 32x32 multiplier into HI/LO
// Optional feature macro: MULT_SIGNED_EN (signed MULT with sign correction; undefined treats op 010 as NOP)
module mul_hilo_ctrl #(
    parameter int MUL_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_start,
    input  logic [63:0] mul_z,
    input  logic        mul_done,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        err
);

    localparam int CNT_W = $clog2(MUL_TIMEOUT + 1);

    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_last;

    logic               acc_multu;
    logic               acc_mult;
    logic               acc_mthi;
    logic               acc_mtlo;
    logic               acc_mul;
    logic [31:0]        op_a_nxt;
    logic [31:0]        op_b_nxt;
    logic               neg_nxt;
    logic [63:0]        product;

`ifdef MULT_SIGNED_EN
    logic               neg;

    // Magnitude of a two's complement word; 0x80000000 maps to itself and is
    // then treated as the unsigned value 2^31 by the multiplier.
    function automatic logic [31:0] mag32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    assign product = neg ? (~mul_z + 64'd1) : mul_z;
`else
    assign product = mul_z;
`endif

    assign cnt_last = (cnt == CNT_W'(MUL_TIMEOUT - 1));

    // Decode the presented op and precompute the operands/sign latched on acceptance
    always_comb begin
        acc_multu = 1'b0;
        acc_mult  = 1'b0;
        acc_mthi  = 1'b0;
        acc_mtlo  = 1'b0;
        op_a_nxt  = rs_data;
        op_b_nxt  = rt_data;
        neg_nxt   = 1'b0;
        if (op_valid && (state == S_IDLE)) begin
            case (op)
                OP_MULTU: acc_multu = 1'b1;
`ifdef MULT_SIGNED_EN
                OP_MULT:  acc_mult  = 1'b1;
`endif
                OP_MTHI:  acc_mthi  = 1'b1;
                OP_MTLO:  acc_mtlo  = 1'b1;
                default:  ;
            endcase
        end
`ifdef MULT_SIGNED_EN
        if (acc_mult) begin
            op_a_nxt = mag32(rs_data);
            op_b_nxt = mag32(rt_data);
            neg_nxt  = rs_data[31] ^ rt_data[31];
        end
`endif
    end

    assign acc_mul = acc_multu | acc_mult;

    // Sequencer: accepts ops in IDLE, runs the start/done handshake, writes HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            mul_start <= 1'b0;
            stall     <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            err       <= 1'b0;
`ifdef MULT_SIGNED_EN
            neg       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (acc_mthi) begin
                        hi <= rs_data;
                    end
                    if (acc_mtlo) begin
                        lo <= rs_data;
                    end
                    if (acc_mul) begin
                        mul_a     <= op_a_nxt;
                        mul_b     <= op_b_nxt;
                        cnt       <= '0;
                        mul_start <= 1'b1;
                        stall     <= 1'b1;
                        state     <= S_LAUNCH;
`ifdef MULT_SIGNED_EN
                        neg       <= neg_nxt;
`endif
                    end
                end
                S_LAUNCH: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt_last) begin
                        mul_start <= 1'b0;
                        stall     <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_IDLE;
                    end else if (!mul_done) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (mul_done) begin
                        mul_start <= 1'b0;
                        state     <= S_WRITE;
                    end else if (cnt_last) begin
                        mul_start <= 1'b0;
                        stall     <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    hi    <= product[63:32];
                    lo    <= product[31:0];
                    stall <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    mul_start <= 1'b0;
                    stall     <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // neg_nxt only feeds the sign register in the signed build
    logic unused_ok;
    assign unused_ok = neg_nxt;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - self-checking bench for mul_hilo_ctrl with a behavioural multiplier and HI/LO model
module tb_mul_hilo_ctrl;

    localparam int TMO = 16;
    localparam int LAT = 11;
`ifdef MULT_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic [63:0] mul_z;
    logic        mul_done;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        err;

    int checks = 0;
    int errors = 0;

    mul_hilo_ctrl #(.MUL_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op        (op),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_start (mul_start),
        .mul_z     (mul_z),
        .mul_done  (mul_done),
        .stall     (stall),
        .hi        (hi),
        .lo        (lo),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Multiplier model: starts on a rising mul_start, busy 8 cycles, done high when idle
    bit hang = 1'b0;
    logic mdl_busy;
    logic start_q;
    int   mdl_left;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done <= 1'b1;
            mdl_busy <= 1'b0;
            start_q  <= 1'b0;
            mdl_left <= 0;
            mul_z    <= '0;
        end else begin
            start_q <= mul_start;
            if (mdl_busy) begin
                if (mdl_left == 0) begin
                    mul_done <= 1'b1;
                    mdl_busy <= 1'b0;
                end else begin
                    mdl_left <= mdl_left - 1;
                end
            end else if (mul_start && !start_q && !hang) begin
                mdl_busy <= 1'b1;
                mul_done <= 1'b0;
                mdl_left <= 7;
                mul_z    <= {32'd0, mul_a} * {32'd0, mul_b};
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference architectural state
    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    task automatic model_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                            output int exp_cyc, output logic [31:0] ea, output logic [31:0] eb);
        longint sp;
        longint m;
        exp_cyc = 0;
        ea = '0;
        eb = '0;
        case (o)
            3'd1: begin
                {ref_hi, ref_lo} = {32'd0, rs} * {32'd0, rt};
                exp_cyc = LAT;
                ea = rs;
                eb = rt;
            end
            3'd2: begin
                if (SIGNED_EN) begin
                    sp = longint'($signed(rs)) * longint'($signed(rt));
                    {ref_hi, ref_lo} = sp;
                    exp_cyc = LAT;
                    m = longint'($signed(rs));
                    if (m < 0) m = -m;
                    ea = m[31:0];
                    m = longint'($signed(rt));
                    if (m < 0) m = -m;
                    eb = m[31:0];
                end
            end
            3'd3: ref_hi = rs;
            3'd4: ref_lo = rs;
            default: ;
        endcase
    endtask

    // Present one op for one cycle, then count stalled cycles (bounded)
    task automatic run_op(input logic [2:0] o, input logic [31:0] rs, input logic [31:0] rt,
                          output int cyc, output logic [31:0] a_seen, output logic [31:0] b_seen,
                          output logic start_seen);
        @(negedge clk);
        op_valid = 1'b1;
        op = o;
        rs_data = rs;
        rt_data = rt;
        @(negedge clk);
        op_valid = 1'b0;
        op = 3'd0;
        a_seen = mul_a;
        b_seen = mul_b;
        start_seen = mul_start;
        cyc = 0;
        while (stall && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int cyc;
        int ecyc;
        logic [31:0] a_s, b_s, ea, eb;
        logic st_s;
        logic [2:0] o;
        logic [31:0] r1, r2;
        logic [31:0] specials[4];

        specials[0] = 32'h0000_0000;
        specials[1] = 32'h8000_0000;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h0000_0001;

        tbl[0] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, LAT};
        tbl[1] = '{3'd2, 32'hFFFF_FFFD, 32'h0000_0007,
                   SIGNED_EN ? 32'hFFFF_FFFF : 32'hFFFF_FFFE,
                   SIGNED_EN ? 32'hFFFF_FFEB : 32'h0000_0001, SIGNED_EN ? LAT : 0};
        tbl[2] = '{3'd2, 32'h8000_0000, 32'h8000_0000,
                   SIGNED_EN ? 32'h4000_0000 : 32'hFFFF_FFFE,
                   SIGNED_EN ? 32'h0000_0000 : 32'h0000_0001, SIGNED_EN ? LAT : 0};
        tbl[3] = '{3'd3, 32'h1234_5678, 32'h0, 32'h1234_5678,
                   SIGNED_EN ? 32'h0000_0000 : 32'h0000_0001, 0};
        tbl[4] = '{3'd4, 32'h9ABC_DEF0, 32'h0, 32'h1234_5678, 32'h9ABC_DEF0, 0};
        tbl[5] = '{3'd2, 32'h0000_0000, 32'hFFFF_FFFB,
                   SIGNED_EN ? 32'h0 : 32'h1234_5678,
                   SIGNED_EN ? 32'h0 : 32'h9ABC_DEF0, SIGNED_EN ? LAT : 0};
        tbl[6] = '{3'd1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0, LAT};
        tbl[7] = '{3'd7, 32'h0000_0001, 32'h0000_0001, 32'h0, 32'h0, 0};
        tbl[8] = '{3'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, LAT};

        reset = 1'b1;
        op_valid = 1'b0;
        op = 3'd0;
        rs_data = '0;
        rt_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_mul_a", mul_a, 0);
        chk("reset_mul_b", mul_b, 0);
        chk("reset_start", mul_start, 0);
        chk("reset_stall", stall, 0);
        chk("reset_err", err, 0);
        reset = 1'b0;

        // Directed vector table
        for (int i = 0; i < 9; i++) begin
            run_op(tbl[i].op, tbl[i].rs, tbl[i].rt, cyc, a_s, b_s, st_s);
            model_op(tbl[i].op, tbl[i].rs, tbl[i].rt, ecyc, ea, eb);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].exp_hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].exp_lo);
            chk($sformatf("tbl%0d_stall_cycles", i), cyc, tbl[i].exp_cyc);
            chk($sformatf("tbl%0d_err", i), err, 0);
            if (SIGNED_EN && i == 1) begin
                chk("mult_neg3_mul_a", a_s, 32'd3);
                chk("mult_neg3_mul_b", b_s, 32'd7);
            end
        end

        // MTHI then MTLO on consecutive cycles, no stall
        @(negedge clk);
        op_valid = 1'b1; op = 3'd3; rs_data = 32'h1234_5678;
        @(negedge clk);
        chk("b2b_mthi_hi", hi, 32'h1234_5678);
        chk("b2b_mthi_stall", stall, 0);
        op = 3'd4; rs_data = 32'h9ABC_DEF0;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        chk("b2b_mtlo_lo", lo, 32'h9ABC_DEF0);
        chk("b2b_mtlo_stall", stall, 0);
        ref_hi = 32'h1234_5678;
        ref_lo = 32'h9ABC_DEF0;

        // MTHI presented during a stall is ignored
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd6;
        @(negedge clk);
        op = 3'd3; rs_data = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        cyc = 0;
        while (stall && cyc < 200) begin cyc++; @(negedge clk); end
        chk("ignored_mthi_hi", hi, 32'h0);
        chk("ignored_mthi_lo", lo, 32'd30);
        ref_hi = 32'h0;
        ref_lo = 32'd30;

        // Randomized ops against the reference model
        for (int i = 0; i < 30; i++) begin
            o = 3'($urandom_range(0, 7));
            r1 = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
            r2 = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 32'($urandom);
            run_op(o, r1, r2, cyc, a_s, b_s, st_s);
            model_op(o, r1, r2, ecyc, ea, eb);
            chk($sformatf("rnd%0d_op%0d_hi", i, o), hi, ref_hi);
            chk($sformatf("rnd%0d_op%0d_lo", i, o), lo, ref_lo);
            chk($sformatf("rnd%0d_op%0d_cycles", i, o), cyc, ecyc);
            if (ecyc != 0) begin
                chk($sformatf("rnd%0d_mul_a", i), a_s, ea);
                chk($sformatf("rnd%0d_mul_b", i), b_s, eb);
                chk($sformatf("rnd%0d_start", i), st_s, 1);
            end
        end
        chk("rnd_err", err, 0);

        // Multiplier never responds: timeout abort
        hang = 1'b1;
        run_op(3'd1, 32'd2, 32'd3, cyc, a_s, b_s, st_s);
        hang = 1'b0;
        chk("tmo_cycles", cyc, TMO);
        chk("tmo_err", err, 1);
        chk("tmo_start", mul_start, 0);
        chk("tmo_hi", hi, ref_hi);
        chk("tmo_lo", lo, ref_lo);

        // Asynchronous reset while waiting on the multiplier
        run_op(3'd3, 32'hA5A5_A5A5, 32'h0, cyc, a_s, b_s, st_s);
        run_op(3'd4, 32'h5A5A_5A5A, 32'h0, cyc, a_s, b_s, st_s);
        @(negedge clk);
        op_valid = 1'b1; op = 3'd1; rs_data = 32'd5; rt_data = 32'd6;
        @(negedge clk);
        op_valid = 1'b0; op = 3'd0;
        repeat (4) @(negedge clk);
        chk("pre_rst_stall", stall, 1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_stall", stall, 0);
        chk("async_rst_start", mul_start, 0);
        chk("async_rst_hi", hi, 0);
        chk("async_rst_lo", lo, 0);
        chk("async_rst_err", err, 0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd1, 32'd5, 32'd6, cyc, a_s, b_s, st_s);
        chk("post_rst_lo", lo, 32'd30);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_cycles", cyc, LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
